// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-read sequencer: master opcodes,
// sequencer states, R/W bit values and the registered command bundle.
package i2c_pkg;

  // Opcodes understood by the byte-level i2c_master command port
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_RSTART = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  // R/W bit appended to the 7-bit device address
  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  // Width of the poll period counter
  localparam int POLL_CNT_W = 26;

  // One state per bus command, plus IDLE
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DEV_W  = 3'd2,
    S_REG    = 3'd3,
    S_RSTART = 3'd4,
    S_DEV_R  = 3'd5,
    S_READ   = 3'd6,
    S_STOP   = 3'd7
  } state_t;

  // Command presented to the master, held stable while cmd_valid is high
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       nack;
  } cmd_t;

endpackage

// File: rtl/poll_timer.sv
// Free-running poll period counter. Counts 0..POLL_CYCLES-1 while enabled and
// flags the last count as a one-cycle tick; held at zero while disabled.
module poll_timer
  import i2c_pkg::*;
#(
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  localparam logic [POLL_CNT_W-1:0] LAST = POLL_CNT_W'(POLL_CYCLES - 1);

  logic [POLL_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at LAST, clear whenever polling is disabled
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + POLL_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/i2c_reg_reader.sv
// Register-read sequencer driving the i2c_master command port:
// START, DEV+W, REG, RSTART, DEV+R, NBYTES x READ, STOP. Each command is
// offered until accepted, then the block waits for its response.
module i2c_reg_reader
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         NBYTES      = 2,
  parameter int         POLL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic [7:0]            reg_addr,
  input  logic                  poll_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   rd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [2:0]            cmd_op,
  output logic [7:0]            cmd_data,
  output logic                  cmd_nack,
  input  logic                  rsp_valid,
  input  logic [7:0]            rsp_data,
  input  logic                  rsp_nack
);

  localparam int         W         = 8 * NBYTES;
  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

  state_t       state_q, state_d;
  logic         waiting_q, waiting_d;     // command accepted, response pending
  logic         pending_q, pending_d;     // one-deep trigger queue
  logic         cmd_valid_q, cmd_valid_d;
  cmd_t         cmd_q, cmd_d;
  logic [7:0]   reg_q, reg_d;             // register pointer latched at start
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         err_flag_q, err_flag_d;   // NACK seen in the running transaction
  logic         err_q, err_d;
  logic         done_q, done_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic         tick;
  logic         trigger;
  logic         issue;

  poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk    (clk),
    .resetn (resetn),
    .en     (poll_en),
    .tick   (tick)
  );

  // Command payload belonging to each state
  function automatic cmd_t cmd_for(input state_t s, input logic [7:0] ptr, input logic last);
    cmd_t c;
    c = '{op: OP_START, data: 8'h00, nack: 1'b0};
    case (s)
      S_START:  c.op = OP_START;
      S_DEV_W:  begin c.op = OP_WRITE; c.data = {DEV_ADDR, I2C_WR}; end
      S_REG:    begin c.op = OP_WRITE; c.data = ptr; end
      S_RSTART: c.op = OP_RSTART;
      S_DEV_R:  begin c.op = OP_WRITE; c.data = {DEV_ADDR, I2C_RD}; end
      S_READ:   begin c.op = OP_READ; c.nack = last; end
      S_STOP:   c.op = OP_STOP;
      default:  c.op = OP_START;
    endcase
    return c;
  endfunction

  assign trigger = pending_q | req | tick;

  // Next-state logic: trigger, handshake, response handling and result capture
  always_comb begin
    state_d     = state_q;
    waiting_d   = waiting_q;
    pending_d   = pending_q | req | tick;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    reg_d       = reg_q;
    byte_cnt_d  = byte_cnt_q;
    shadow_d    = shadow_q;
    err_flag_d  = err_flag_q;
    err_d       = err_q;
    done_d      = 1'b0;
    rd_data_d   = rd_data_q;
    issue       = 1'b0;

    if (state_q == S_IDLE) begin
      if (trigger) begin
        pending_d  = 1'b0;
        reg_d      = reg_addr;
        err_flag_d = 1'b0;
        byte_cnt_d = '0;
        state_d    = S_START;
        issue      = 1'b1;
      end
    end else if (cmd_valid_q) begin
      if (cmd_ready) begin
        cmd_valid_d = 1'b0;
        waiting_d   = 1'b1;
      end
    end else if (waiting_q && rsp_valid) begin
      waiting_d = 1'b0;
      issue     = 1'b1;
      case (state_q)
        S_START:  state_d = S_DEV_W;
        S_DEV_W:  begin
          state_d    = rsp_nack ? S_STOP : S_REG;
          err_flag_d = err_flag_q | rsp_nack;
        end
        S_REG:    begin
          state_d    = rsp_nack ? S_STOP : S_RSTART;
          err_flag_d = err_flag_q | rsp_nack;
        end
        S_RSTART: state_d = S_DEV_R;
        S_DEV_R:  begin
          state_d    = rsp_nack ? S_STOP : S_READ;
          err_flag_d = err_flag_q | rsp_nack;
          byte_cnt_d = '0;
        end
        S_READ:   begin
          shadow_d = (shadow_q << 8) | W'(rsp_data);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        S_STOP:   begin
          state_d = S_IDLE;
          issue   = 1'b0;
          done_d  = 1'b1;
          err_d   = err_flag_q;
          if (!err_flag_q) begin
            rd_data_d = shadow_q;
          end
        end
        default:  begin
          state_d = S_IDLE;
          issue   = 1'b0;
        end
      endcase
    end

    if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_for(state_d, reg_d, byte_cnt_d == LAST_BYTE);
    end
  end

  // State and output registers; reset parks the sequencer in IDLE with all outputs low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      waiting_q   <= 1'b0;
      pending_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      reg_q       <= '0;
      byte_cnt_q  <= '0;
      shadow_q    <= '0;
      err_flag_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      waiting_q   <= waiting_d;
      pending_q   <= pending_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      reg_q       <= reg_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      err_flag_q  <= err_flag_d;
      err_q       <= err_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_q.op;
  assign cmd_data  = cmd_q.data;
  assign cmd_nack  = cmd_q.nack;

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Self-checking bench for i2c_reg_reader: a behavioural master/slave that logs
// every accepted command, a transaction-level reference model, a directed
// vector table, multi-cycle corner sequences and randomized transactions.
module tb_i2c_reg_reader;

  localparam logic [6:0] DEV = 7'h68;
  localparam int         NB  = 2;
  localparam int         PC  = 20;

  localparam logic [2:0] C_START  = 3'd0;
  localparam logic [2:0] C_RSTART = 3'd1;
  localparam logic [2:0] C_WRITE  = 3'd2;
  localparam logic [2:0] C_READ   = 3'd3;
  localparam logic [2:0] C_STOP   = 3'd4;

  logic        clk, resetn, req, poll_en;
  logic [7:0]  reg_addr;
  logic        busy, done, err;
  logic [15:0] rd_data;
  logic        cmd_valid, cmd_ready, cmd_nack;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;

  i2c_reg_reader #(.DEV_ADDR(DEV), .NBYTES(NB), .POLL_CYCLES(PC)) dut (
    .clk(clk), .resetn(resetn), .req(req), .reg_addr(reg_addr), .poll_en(poll_en),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- master / slave model ----------------
  int         m_ready_dly = 0;   // cycles cmd_ready stays low per command
  int         m_rsp_dly   = 1;   // cycles from acceptance to rsp_valid (>=1)
  int         m_nack_idx  = -1;  // command index in transaction that gets NACK
  logic [7:0] slave_bytes [4];
  int         m_spur_req  = 0;
  int         m_spur_done = 0;
  int         m_rsp_cnt, m_seen, m_idx, m_rd_idx, viol;
  logic [7:0] m_rdata;
  logic       m_rnack, rdy;
  logic [11:0] m_first;
  logic [11:0] log_q[$];         // accepted commands {op, data, nack}

  initial begin
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_data = 0;
    m_rsp_cnt = 0; m_seen = 0; m_idx = 0; m_rd_idx = 0; viol = 0;
    m_rdata = 0; m_rnack = 0; m_first = 0;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      m_rsp_cnt = 0; m_seen = 0; m_idx = 0; m_rd_idx = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_nack = 0;
    end else begin
      rsp_valid = 0;
      rsp_nack  = 0;
      if (m_spur_done != m_spur_req) begin
        m_spur_done = m_spur_req;
        rsp_valid = 1; rsp_nack = 1; rsp_data = 8'hEE;
      end else if (m_rsp_cnt > 0) begin
        m_rsp_cnt--;
        if (m_rsp_cnt == 0) begin
          rsp_valid = 1; rsp_data = m_rdata; rsp_nack = m_rnack;
        end
      end
      if (cmd_valid && (m_rsp_cnt > 0 || rsp_valid)) viol++;
      if (!cmd_valid && m_seen > 0) viol++;
      if (cmd_valid && m_seen > 0 && {cmd_op, cmd_data, cmd_nack} != m_first) viol++;
      if (cmd_valid) begin
        if (m_seen == 0) m_first = {cmd_op, cmd_data, cmd_nack};
        rdy = (m_seen >= m_ready_dly);
        m_seen++;
      end else begin
        rdy = (m_ready_dly == 0);
        m_seen = 0;
      end
      cmd_ready = rdy;
      if (cmd_valid && rdy) begin
        log_q.push_back({cmd_op, (cmd_op == C_WRITE) ? cmd_data : 8'h00,
                         (cmd_op == C_READ) ? cmd_nack : 1'b0});
        if (cmd_op == C_START) begin m_idx = 0; m_rd_idx = 0; end
        m_rnack = (m_idx == m_nack_idx);
        m_rdata = 8'h00;
        if (cmd_op == C_READ) begin
          m_rdata = slave_bytes[m_rd_idx % 4];
          m_rd_idx++;
        end
        m_idx++;
        m_rsp_cnt = m_rsp_dly;
        m_seen = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   done_cnt = 0;
  logic busy_prev = 0;
  int   rise_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy && !busy_prev) rise_q.push_back(cyc);
    busy_prev = busy;
    if (done) done_cnt++;
  end

  // ---------------- reference model ----------------
  logic [11:0] exp_q[$];
  logic [15:0] model_rd = 16'h0000;

  // Command script of one transaction; a NACK at command k ends it with STOP
  task automatic model_txn(input logic [7:0] ra, input int nk);
    logic [11:0] s[$];
    s.push_back({C_START, 8'h00, 1'b0});
    s.push_back({C_WRITE, {DEV, 1'b0}, 1'b0});
    s.push_back({C_WRITE, ra, 1'b0});
    s.push_back({C_RSTART, 8'h00, 1'b0});
    s.push_back({C_WRITE, {DEV, 1'b1}, 1'b0});
    for (int i = 0; i < NB; i++) s.push_back({C_READ, 8'h00, (i == NB - 1)});
    if (nk >= 0) while (s.size() > nk + 1) void'(s.pop_back());
    s.push_back({C_STOP, 8'h00, 1'b0});
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic compare_log(input int base, input string tag);
    int n;
    n = log_q.size() - base;
    check({tag, "_ncmds_model"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), log_q[base + i], exp_q[i]);
  endtask

  task automatic pulse_req(input logic [7:0] ra);
    @(negedge clk); reg_addr = ra; req = 1;
    @(negedge clk); req = 0;
  endtask

  // One request-driven transaction, checked end to end
  task automatic run_txn(input logic [7:0] ra, input logic [7:0] b0, input logic [7:0] b1,
                         input int nk, input int rdly, input int rspd,
                         input logic [15:0] exp_rd, input logic exp_err, input int exp_n,
                         input string tag);
    int base;
    logic got;
    m_ready_dly = rdly; m_rsp_dly = rspd; m_nack_idx = nk;
    slave_bytes[0] = b0; slave_bytes[1] = b1;
    exp_q.delete();
    model_txn(ra, nk);
    base = log_q.size();
    pulse_req(ra);
    check({tag, "_start"}, {busy, cmd_valid, cmd_op}, {1'b1, 1'b1, C_START});
    reg_addr = ~ra;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_rd_data"}, rd_data, exp_rd);
    check({tag, "_err"}, err, exp_err);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_err_held"}, err, exp_err);
    check({tag, "_ncmds"}, log_q.size() - base, exp_n);
    compare_log(base, tag);
  endtask

  typedef struct {
    logic [7:0]  ra, b0, b1;
    int          nk, rdly, rspd;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, c_en, r0, nk, nsel;
    logic [7:0] ra, b0, b1;
    logic [15:0] erd;
    logic got;

    vecs[0] = '{8'h3B, 8'hA5, 8'h5A, -1, 0, 1, 16'hA55A, 1'b0, 8};
    vecs[1] = '{8'h10, 8'h11, 8'h22,  1, 1, 1, 16'hA55A, 1'b1, 3};
    vecs[2] = '{8'h20, 8'hC3, 8'h3C, -1, 5, 2, 16'hC33C, 1'b0, 8};
    vecs[3] = '{8'h44, 8'h01, 8'h02,  2, 0, 3, 16'hC33C, 1'b1, 4};
    vecs[4] = '{8'h55, 8'h77, 8'h88,  4, 2, 1, 16'hC33C, 1'b1, 6};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, -1, 0, 1, 16'h00FF, 1'b0, 8};

    resetn = 1; req = 0; poll_en = 0; reg_addr = 8'h00;
    #3 resetn = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_cmd", {cmd_valid, cmd_op, cmd_data, cmd_nack}, 0);
    check("rst_rd_data", rd_data, 0);
    resetn = 1;
    repeat (2) @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].ra, vecs[i].b0, vecs[i].b1, vecs[i].nk, vecs[i].rdly, vecs[i].rspd,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_n, $sformatf("vec%0d", i));
    model_rd = 16'h00FF;

    // Response with nothing outstanding is ignored
    d0 = done_cnt; base = log_q.size();
    @(negedge clk); m_spur_req++;
    repeat (5) @(negedge clk);
    check("spur_busy", busy, 0);
    check("spur_no_activity", (done_cnt - d0) + (log_q.size() - base), 0);

    // Two requests during a busy transaction -> exactly one follow-up
    m_ready_dly = 0; m_rsp_dly = 1; m_nack_idx = -1;
    slave_bytes[0] = 8'h9C; slave_bytes[1] = 8'h4E;
    exp_q.delete(); model_txn(8'h3B, -1); model_txn(8'h77, -1);
    base = log_q.size(); d0 = done_cnt;
    pulse_req(8'h3B);
    reg_addr = 8'h12;
    repeat (3) @(negedge clk);
    check("q_busy_1st_pulse", busy, 1);
    pulse_req(8'h12);
    repeat (2) @(negedge clk);
    pulse_req(8'h12);
    reg_addr = 8'h77;
    for (int i = 0; i < 300 && (done_cnt - d0) < 2; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("q_done_count", done_cnt - d0, 2);
    check("q_rd_data", rd_data, 16'h9C4E);
    compare_log(base, "q");
    model_rd = 16'h9C4E;

    // Poll timer: start 1 cycle after each tick; req coinciding with tick -> one txn
    slave_bytes[0] = 8'h13; slave_bytes[1] = 8'h37;
    reg_addr = 8'h42;
    d0 = done_cnt; r0 = rise_q.size();
    @(negedge clk); poll_en = 1; c_en = cyc;
    repeat (19) @(negedge clk);
    req = 1;
    @(negedge clk); req = 0;
    repeat (42) @(negedge clk);
    poll_en = 0;
    repeat (2) @(negedge clk);
    check("poll_cnt_cleared", dut.u_poll_timer.cnt_q, 0);
    repeat (60) @(negedge clk);
    check("poll_starts", rise_q.size() - r0, 3);
    for (int k = 1; k <= 3 && r0 + k - 1 < rise_q.size(); k++)
      check($sformatf("poll_start_cycle%0d", k), rise_q[r0 + k - 1] - c_en, k * PC);
    check("poll_done_count", done_cnt - d0, 3);
    check("poll_rd_data", rd_data, 16'h1337);
    model_rd = 16'h1337;

    // Randomized transactions against the reference model
    for (int t = 0; t < 20; t++) begin
      ra = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
      nsel = $urandom_range(0, 5);
      nk = (nsel == 3) ? 1 : (nsel == 4) ? 2 : (nsel == 5) ? 4 : -1;
      erd = (nk < 0) ? {b0, b1} : model_rd;
      run_txn(ra, b0, b1, nk, $urandom_range(0, 3), $urandom_range(1, 3),
              erd, (nk >= 0), (nk < 0) ? 6 + NB : nk + 2, $sformatf("rnd%0d", t));
      model_rd = erd;
    end

    // Asynchronous reset in the middle of a READ
    if (model_rd == 16'h0000) run_txn(8'h01, 8'h5C, 8'hC5, -1, 0, 1, 16'h5CC5, 1'b0, 8, "pre_rst");
    m_ready_dly = 1; m_rsp_dly = 3; m_nack_idx = -1;
    slave_bytes[0] = 8'h66; slave_bytes[1] = 8'h99;
    pulse_req(8'h0F);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid && cmd_op == C_READ) begin got = 1; break; end
      @(negedge clk);
    end
    check("rst_reached_read", got, 1);
    check("rst_rd_nonzero_before", (rd_data != 16'h0000), 1);
    #2 resetn = 0;
    #1;
    check("arst_busy_done_err", {busy, done, err}, 0);
    check("arst_cmd", {cmd_valid, cmd_op, cmd_data, cmd_nack}, 0);
    check("arst_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk); resetn = 1;
    base = log_q.size(); d0 = done_cnt;
    repeat (30) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_cmds", (log_q.size() - base) + (done_cnt - d0), 0);
    run_txn(8'h3B, 8'hA5, 8'h5A, -1, 0, 1, 16'hA55A, 1'b0, 8, "post_rst");

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
